// File: rtl/cache_store_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// my_struct_package : shared types, opcodes and FSM states for cache_store
// Rev 1.0
// ---------------------------------------------------------------------------
package my_struct_package;

    localparam int OFFSET_W    = 6;
    localparam int SET_FIELD_W = 14;
    localparam int TAG_W       = 12;
    localparam int LRU_W       = 3;
    localparam int CNT_W       = 32;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_t;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_READ  = 4'd0;
    localparam opcode_t OP_WRITE = 4'd1;
    localparam opcode_t OP_FETCH = 4'd2;
    localparam opcode_t OP_OP3   = 4'd3;
    localparam opcode_t OP_OP4   = 4'd4;
    localparam opcode_t OP_CLEAR = 4'd8;
    localparam opcode_t OP_NOP   = 4'd9;

    typedef struct packed {
        logic [TAG_W-1:0]       tag;
        logic [SET_FIELD_W-1:0] set;
        logic [OFFSET_W-1:0]    offset;
    } address_t;

    typedef struct packed {
        opcode_t  n;
        address_t address;
    } command_t;

    typedef struct packed {
        mesi_t            mesi_bits;
        logic [TAG_W-1:0] tag;
        logic [LRU_W-1:0] lru;
    } cache_line_t;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_store_set_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// set_ram : WAYS-wide line storage, one write port, one registered read port
// Rev 1.0
// ---------------------------------------------------------------------------
module set_ram
    import my_struct_package::*;
#(
    parameter int WAYS = 8,
    parameter int SETS = 16384,
    parameter int AW   = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic                         clk,
    input  logic                         i_rd_en,
    input  logic [AW-1:0]                i_rd_addr,
    output cache_line_t [WAYS-1:0]       o_rd_data,
    input  logic                         i_wr_en,
    input  logic [AW-1:0]                i_wr_addr,
    input  cache_line_t [WAYS-1:0]       i_wr_data
);

    cache_line_t [WAYS-1:0] r_mem [SETS];

    // Read data only moves on a read, so it stays valid for the whole command.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_store.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_store : I/D set store with clear sweep, issue/commit handshake, stats
// Rev 1.0
// ---------------------------------------------------------------------------
module cache_store
    import my_struct_package::*;
#(
    parameter int SETS   = 16384,
    parameter int D_WAYS = 8,
    parameter int I_WAYS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  command_t                   cmd,
    output logic                       cmd_ready,
    output cache_line_t [D_WAYS-1:0]   line_d_o,
    output cache_line_t [I_WAYS-1:0]   line_i_o,
    output command_t                   issue_o,
    output logic                       issue_valid_o,
    input  cache_line_t [D_WAYS-1:0]   ret_d_i,
    input  cache_line_t [I_WAYS-1:0]   ret_i_i,
    input  logic                       ret_valid_i,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           rd_cnt_o,
    output logic [CNT_W-1:0]           wr_cnt_o,
    output logic [CNT_W-1:0]           hit_cnt_o,
    output logic [CNT_W-1:0]           miss_cnt_o
);

    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

    state_t                   r_state;
    state_t                   w_next;
    logic [SET_W-1:0]         r_sweep;
    command_t                 r_cmd;
    cache_line_t [D_WAYS-1:0] r_ret_d;
    cache_line_t [I_WAYS-1:0] r_ret_i;
    cache_line_t [D_WAYS-1:0] w_clr_d;
    cache_line_t [I_WAYS-1:0] w_clr_i;

    logic                     w_accept;
    logic                     w_rd_en;
    logic [SET_W-1:0]         w_wr_set;
    logic                     w_wr_d;
    logic                     w_wr_i;
    logic                     w_hit_d;
    logic                     w_hit_i;
    logic                     w_hit;

    assign cmd_ready     = (r_state == ST_IDLE);
    assign busy_o        = (r_state == ST_CLEAR);
    assign issue_valid_o = (r_state == ST_EXEC);
    assign issue_o       = r_cmd;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_rd_en  = w_accept && (cmd.n <= OP_OP4);
    assign w_wr_set = (r_state == ST_CLEAR) ? r_sweep : r_cmd.address.set[SET_W-1:0];

    // Writes are gated by rst so an abandoned command can never commit.
    assign w_wr_d = !rst && ((r_state == ST_CLEAR) ||
                             ((r_state == ST_COMMIT) && (r_cmd.n != OP_FETCH)));
    assign w_wr_i = !rst && ((r_state == ST_CLEAR) ||
                             ((r_state == ST_COMMIT) && (r_cmd.n == OP_FETCH)));

    genvar gw;
    generate
        for (gw = 0; gw < D_WAYS; gw++) begin : g_clr_d
            assign w_clr_d[gw] = '{mesi_bits: MESI_I, tag: '0, lru: LRU_W'(gw)};
        end
        for (gw = 0; gw < I_WAYS; gw++) begin : g_clr_i
            assign w_clr_i[gw] = '{mesi_bits: MESI_I, tag: '0, lru: LRU_W'(gw)};
        end
    endgenerate

    set_ram #(.WAYS(D_WAYS), .SETS(SETS), .AW(SET_W)) u_d_ram (
        .clk       (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (cmd.address.set[SET_W-1:0]),
        .o_rd_data (line_d_o),
        .i_wr_en   (w_wr_d),
        .i_wr_addr (w_wr_set),
        .i_wr_data ((r_state == ST_CLEAR) ? w_clr_d : r_ret_d)
    );

    set_ram #(.WAYS(I_WAYS), .SETS(SETS), .AW(SET_W)) u_i_ram (
        .clk       (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (cmd.address.set[SET_W-1:0]),
        .o_rd_data (line_i_o),
        .i_wr_en   (w_wr_i),
        .i_wr_addr (w_wr_set),
        .i_wr_data ((r_state == ST_CLEAR) ? w_clr_i : r_ret_i)
    );

    always_comb begin
        w_hit_d = 1'b0;
        w_hit_i = 1'b0;
        for (int w = 0; w < D_WAYS; w++) begin
            if ((line_d_o[w].mesi_bits != MESI_I) && (line_d_o[w].tag == r_cmd.address.tag)) begin
                w_hit_d = 1'b1;
            end
        end
        for (int w = 0; w < I_WAYS; w++) begin
            if ((line_i_o[w].mesi_bits != MESI_I) && (line_i_o[w].tag == r_cmd.address.tag)) begin
                w_hit_i = 1'b1;
            end
        end
        w_hit = (r_cmd.n == OP_FETCH) ? w_hit_i : w_hit_d;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR:  if (r_sweep == SET_W'(SETS - 1)) w_next = ST_IDLE;
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd.n <= OP_OP4)        w_next = ST_LOOKUP;
                    else if (cmd.n == OP_CLEAR) w_next = ST_CLEAR;
                end
            end
            ST_LOOKUP: w_next = ST_EXEC;
            ST_EXEC:   if (ret_valid_i) w_next = ST_COMMIT;
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_sweep <= '0;
            r_cmd   <= '0;
        end else begin
            r_state <= w_next;
            r_sweep <= (r_state == ST_CLEAR) ? r_sweep + 1'b1 : '0;
            if (w_rd_en) begin
                r_cmd <= cmd;
            end
        end
    end

    // Returned sets are captured so COMMIT does not depend on ret_*_i being held.
    always_ff @(posedge clk) begin
        if ((r_state == ST_EXEC) && ret_valid_i) begin
            r_ret_d <= ret_d_i;
            r_ret_i <= ret_i_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_o   <= '0;
            wr_cnt_o   <= '0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (w_accept && (cmd.n == OP_CLEAR)) begin
            rd_cnt_o   <= '0;
            wr_cnt_o   <= '0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if ((r_cmd.n == OP_READ) || (r_cmd.n == OP_FETCH)) rd_cnt_o <= sat_inc(rd_cnt_o);
            if (r_cmd.n == OP_WRITE) wr_cnt_o <= sat_inc(wr_cnt_o);
            if (r_cmd.n <= OP_FETCH) begin
                if (w_hit) hit_cnt_o  <= sat_inc(hit_cnt_o);
                else       miss_cnt_o <= sat_inc(miss_cnt_o);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_store.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cache_store : directed + random commands against an array/counter model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cache_store;
    import my_struct_package::*;

    localparam int SETS = 16;
    localparam int DW   = 8;
    localparam int IW   = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid = 1'b0;
    command_t              cmd = '0;
    logic                  cmd_ready;
    cache_line_t [DW-1:0]  line_d_o;
    cache_line_t [IW-1:0]  line_i_o;
    command_t              issue_o;
    logic                  issue_valid_o;
    cache_line_t [DW-1:0]  ret_d_i = '0;
    cache_line_t [IW-1:0]  ret_i_i = '0;
    logic                  ret_valid_i = 1'b0;
    logic                  busy_o;
    logic [31:0]           rd_cnt_o, wr_cnt_o, hit_cnt_o, miss_cnt_o;

    cache_store #(.SETS(SETS), .D_WAYS(DW), .I_WAYS(IW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .line_d_o(line_d_o), .line_i_o(line_i_o), .issue_o(issue_o),
        .issue_valid_o(issue_valid_o), .ret_d_i(ret_d_i), .ret_i_i(ret_i_i),
        .ret_valid_i(ret_valid_i), .busy_o(busy_o), .rd_cnt_o(rd_cnt_o),
        .wr_cnt_o(wr_cnt_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    cache_line_t md [SETS][DW];
    cache_line_t mi [SETS][IW];
    int unsigned m_rd, m_wr, m_hit, m_miss;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < DW; w++) md[s][w] = '{mesi_bits: MESI_I, tag: '0, lru: LRU_W'(w)};
            for (int w = 0; w < IW; w++) mi[s][w] = '{mesi_bits: MESI_I, tag: '0, lru: LRU_W'(w)};
        end
        m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
    endtask

    function automatic logic [255:0] exp_d(input int s);
        cache_line_t [DW-1:0] e;
        for (int w = 0; w < DW; w++) e[w] = md[s][w];
        return 256'(e);
    endfunction

    function automatic logic [255:0] exp_i(input int s);
        cache_line_t [IW-1:0] e;
        for (int w = 0; w < IW; w++) e[w] = mi[s][w];
        return 256'(e);
    endfunction

    function automatic cache_line_t rand_line();
        return '{mesi_bits: mesi_t'(2'($urandom_range(0, 3))),
                 tag: TAG_W'($urandom_range(0, 3)), lru: LRU_W'($urandom_range(0, 7))};
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_rd"},   256'(rd_cnt_o),   256'(m_rd));
        chk({tag, "_wr"},   256'(wr_cnt_o),   256'(m_wr));
        chk({tag, "_hit"},  256'(hit_cnt_o),  256'(m_hit));
        chk({tag, "_miss"}, 256'(miss_cnt_o), 256'(m_miss));
    endtask

    // Call on the first negedge of a sweep; counts busy cycles until IDLE.
    task automatic count_busy(input string tag);
        int cnt = 0;
        bit ready_seen = 1'b0;
        while (busy_o && cnt < 1000) begin
            if (cmd_ready) ready_seen = 1'b1;
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_len"}, 256'(cnt), 256'(SETS));
        chk({tag, "_ready_during"}, 256'(ready_seen), 256'(0));
        chk({tag, "_ready_after"}, 256'(cmd_ready), 256'(1));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 256'(cmd_ready), 256'(1));
    endtask

    task automatic do_cmd(input logic [3:0] n, input logic [31:0] addr, input int delay,
                          input bit make_hit, input bit rst_exec);
        command_t              c;
        int                    s;
        bit                    hit;
        logic [TAG_W-1:0]      tg;
        cache_line_t [DW-1:0]  rd;
        cache_line_t [IW-1:0]  ri;
        wait_ready();
        c.n = n;
        c.address = address_t'(addr);
        s  = int'((addr >> OFFSET_W) % SETS);
        tg = TAG_W'(addr >> (OFFSET_W + SET_FIELD_W));
        cmd = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (n <= 4) begin
            chk("lookup_issue_valid", 256'(issue_valid_o), 256'(0));
            chk("lookup_ready", 256'(cmd_ready), 256'(0));
            ret_valid_i = 1'($urandom_range(0, 1));
            for (int w = 0; w < DW; w++) ret_d_i[w] = rand_line();
            @(negedge clk);
            ret_valid_i = 1'b0;
            hit = 1'b0;
            if (n == 0 || n == 1) begin
                for (int w = 0; w < DW; w++) if (md[s][w].mesi_bits != MESI_I && md[s][w].tag == tg) hit = 1'b1;
            end else if (n == 2) begin
                for (int w = 0; w < IW; w++) if (mi[s][w].mesi_bits != MESI_I && mi[s][w].tag == tg) hit = 1'b1;
            end
            if (n == 0 || n == 2) m_rd++;
            if (n == 1) m_wr++;
            if (n <= 2) begin
                if (hit) m_hit++;
                else     m_miss++;
            end
            chk("exec_issue_valid", 256'(issue_valid_o), 256'(1));
            chk("issue_o", 256'(issue_o), 256'(c));
            chk("line_d", 256'(line_d_o), exp_d(s));
            chk("line_i", 256'(line_i_o), exp_i(s));
            chk_counters("exec");
            if (rst_exec) begin
                rst = 1'b1;
                ret_valid_i = 1'b1;
                @(negedge clk);
                chk("rst_busy", 256'(busy_o), 256'(1));
                chk("rst_ready", 256'(cmd_ready), 256'(0));
                chk("rst_issue", 256'(issue_valid_o), 256'(0));
                model_clear();
                chk_counters("rst_exec");
                rst = 1'b0;
                ret_valid_i = 1'b0;
                count_busy("rst_exec_clear");
                return;
            end
            for (int k = 0; k < delay; k++) begin
                @(negedge clk);
                chk("hold_issue_valid", 256'(issue_valid_o), 256'(1));
                chk("hold_ready", 256'(cmd_ready), 256'(0));
            end
            for (int w = 0; w < DW; w++) begin
                rd[w] = rand_line();
                if (make_hit) begin rd[w].mesi_bits = MESI_M; rd[w].tag = tg; end
            end
            for (int w = 0; w < IW; w++) begin
                ri[w] = rand_line();
                if (make_hit) begin ri[w].mesi_bits = MESI_M; ri[w].tag = tg; end
            end
            ret_d_i = rd;
            ret_i_i = ri;
            ret_valid_i = 1'b1;
            @(negedge clk);
            ret_valid_i = 1'b0;
            for (int w = 0; w < DW; w++) ret_d_i[w] = rand_line();
            for (int w = 0; w < IW; w++) ret_i_i[w] = rand_line();
            chk("commit_issue_valid", 256'(issue_valid_o), 256'(0));
            chk("commit_ready", 256'(cmd_ready), 256'(0));
            if (n == 2) for (int w = 0; w < IW; w++) mi[s][w] = ri[w];
            else        for (int w = 0; w < DW; w++) md[s][w] = rd[w];
            @(negedge clk);
            chk("next_accept_ready", 256'(cmd_ready), 256'(1));
        end else if (n == 8) begin
            chk("clr_busy", 256'(busy_o), 256'(1));
            chk("clr_issue", 256'(issue_valid_o), 256'(0));
            model_clear();
            chk_counters("clr");
            count_busy("clr_sweep");
        end else begin
            chk("drop_ready", 256'(cmd_ready), 256'(1));
            chk("drop_issue", 256'(issue_valid_o), 256'(0));
            chk("drop_busy", 256'(busy_o), 256'(0));
            chk_counters("drop");
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return (32'($urandom_range(0, 3)) << 20) |
               (32'($urandom_range(0, (1 << SET_FIELD_W) - 1)) << OFFSET_W) |
               32'($urandom_range(0, 63));
    endfunction

    initial begin
        logic [3:0] ops [8];
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd3;
        ops[4] = 4'd4; ops[5] = 4'd9; ops[6] = 4'd6; ops[7] = 4'd0;

        repeat (2) @(negedge clk);
        chk("reset_ready", 256'(cmd_ready), 256'(0));
        chk("reset_busy", 256'(busy_o), 256'(1));
        chk("reset_issue", 256'(issue_valid_o), 256'(0));
        model_clear();
        chk_counters("reset");
        rst = 1'b0;
        count_busy("reset_clear");

        // Read miss, then same address hits and returns the committed set.
        do_cmd(4'd0, 32'h0000_0040, 0, 1'b1, 1'b0);
        chk("miss_rd_abs", 256'(rd_cnt_o), 256'(1));
        chk("miss_miss_abs", 256'(miss_cnt_o), 256'(1));
        do_cmd(4'd0, 32'h0000_0040, 0, 1'b0, 1'b0);
        chk("hit_hit_abs", 256'(hit_cnt_o), 256'(1));

        do_cmd(4'd0, 32'h0000_0000, 0, 1'b0, 1'b0);
        do_cmd(4'd2, 32'h0000_0040, 0, 1'b0, 1'b0);
        do_cmd(4'd0, 32'h0000_0040, 0, 1'b0, 1'b0);
        do_cmd(4'd1, 32'h0010_0080, 5, 1'b0, 1'b0);
        do_cmd(4'd9, 32'h0000_0080, 0, 1'b0, 1'b0);
        do_cmd(4'd5, 32'h0000_00C0, 0, 1'b0, 1'b0);
        do_cmd(4'd15, 32'h0000_00C0, 0, 1'b0, 1'b0);
        // Set field above the low bits must alias onto set 1.
        do_cmd(4'd0, 32'h000F_FC40, 0, 1'b0, 1'b0);
        do_cmd(4'd8, 32'h0, 0, 1'b0, 1'b0);
        do_cmd(4'd0, 32'h0000_0040, 0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            do_cmd(ops[$urandom_range(0, 7)], rand_addr(), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        do_cmd(4'd0, 32'h0000_0040, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            do_cmd(ops[$urandom_range(0, 7)], rand_addr(), int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cache_store.md
CACHE_STORE -- requirements
Module: cache_store

Interface
REQ-001 Parameter SETS, default 16384, number of sets in each of the I and D arrays (power of 2).
REQ-002 Parameter D_WAYS, default 8; parameter I_WAYS, default 4.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  a trace command is presented.
REQ-006 cmd  in  command_t  command: opcode n and address (tag, set index, byte offset).
REQ-007 cmd_ready  out  1  the store accepts cmd this cycle.
REQ-008 line_d_o  out  cache_line_t[D_WAYS]  D set addressed by the accepted command.
REQ-009 line_i_o  out  cache_line_t[I_WAYS]  I set addressed by the accepted command.
REQ-010 issue_o  out  command_t  accepted command, held stable until commit.
REQ-011 issue_valid_o  out  1  line_*_o and issue_o are valid for the processor stage.
REQ-012 ret_d_i  in  cache_line_t[D_WAYS]  updated D set from the processor stage.
REQ-013 ret_i_i  in  cache_line_t[I_WAYS]  updated I set from the processor stage.
REQ-014 ret_valid_i  in  1  ret_*_i is valid for the issued command.
REQ-015 busy_o  out  1  clear sweep in progress.
REQ-016 rd_cnt_o, wr_cnt_o, hit_cnt_o, miss_cnt_o  out  32 each  statistics counters.

Function
REQ-017 The FSM SHALL have states CLEAR, IDLE, LOOKUP, EXEC and COMMIT.
REQ-018 In IDLE, cmd_ready SHALL be 1; cmd_valid&&cmd_ready SHALL latch cmd and go to LOOKUP (accept cycle is cycle 0).
REQ-019 LOOKUP SHALL read set cmd.address.set from both arrays; issue_valid_o SHALL rise in cycle 2 and the FSM SHALL enter EXEC.
REQ-020 In EXEC, issue_valid_o SHALL stay 1 until ret_valid_i; on ret_valid_i the FSM SHALL go to COMMIT.
REQ-021 In COMMIT, the store SHALL write ret_d_i for n in {0,1,3,4}, or ret_i_i for n=2, to the latched set, drop issue_valid_o, and return to IDLE; at most one array is written per command.
REQ-022 Command-to-next-accept latency SHALL be 4 cycles when ret_valid_i is asserted in the first EXEC cycle.
REQ-023 n=8 SHALL enter CLEAR without issuing to the processor stage.
REQ-024 n=9 SHALL be consumed in one cycle: no issue, no write, no counter change.
REQ-025 Other n values SHALL be dropped like n=9.
REQ-026 CLEAR SHALL write every way of set k with MESI_bits=I, tag=0 and LRU equal to the way index, one set per cycle, for k = 0..SETS-1; it SHALL take SETS cycles with busy_o=1 and cmd_ready=0, then go to IDLE.
REQ-027 Hit SHALL be a tag match with MESI_bits != I in the addressed array (D for n=0,1; I for n=2), evaluated in LOOKUP from the read lines.
REQ-028 On entry to EXEC: n=0 and n=2 SHALL increment rd_cnt_o; n=1 SHALL increment wr_cnt_o; each of n=0,1,2 SHALL increment exactly one of hit_cnt_o or miss_cnt_o.
REQ-029 Counters SHALL saturate at 32'hFFFF_FFFF.
REQ-030 Counters SHALL be cleared by rst and by n=8.
REQ-031 ret_valid_i outside EXEC SHALL be ignored.
REQ-032 cmd_valid while cmd_ready=0 SHALL NOT be accepted; the source holds cmd stable.
REQ-033 Set index SHALL be taken modulo SETS, with no wrap into an adjacent set.

Reset
REQ-034 rst SHALL asynchronously force state CLEAR with sweep index 0.
REQ-035 rst SHALL force cmd_ready=0, issue_valid_o=0, busy_o=1 and all counters to 0.
REQ-036 rst asserted mid-command SHALL abandon the command with no array write.
REQ-037 Array contents SHALL be initialised only by the CLEAR sweep, never by rst directly.

Structure
REQ-038 command_t, cache_line_t, the MESI encoding (I=2'b00), the opcode constants and the FSM state enum SHALL live in my_struct_package.
REQ-039 One sub-module, set_ram (parameterised ways × SETS, one read port and one write port, registered read), SHALL be instantiated twice, once for D and once for I.

Verification
REQ-040 Reset: after rst release, busy_o=1 for exactly 16 cycles (SETS=16), then cmd_ready=1; all set-0 D ways read MESI=I with LRU=0..7.
REQ-041 Read miss: n=0, address 32'h0000_0040 -> issue_valid_o in cycle 2; after ret_valid_i, rd_cnt_o=1 and miss_cnt_o=1; re-issuing the same address returns the committed line, and hit_cnt_o=1.
REQ-042 Fetch: n=2 -> only the I array is written; the D set is unchanged; rd_cnt_o increments.
REQ-043 ret_valid_i delayed 5 cycles -> issue_valid_o held and cmd_ready=0 throughout; one write follows.
REQ-044 n=8 after 3 commands -> counters become 0, busy_o=1 for SETS cycles, and all lines are invalid.
REQ-045 rst pulsed during EXEC -> no array write occurs, and the FSM restarts in CLEAR.
